seq_div: RTL and testbench
==========================

# seq_div

Sequential W-bit restoring divider, the inverse companion to the team's ripple adder-subtractor. It takes a dividend and divisor through a start/done handshake and produces quotient, remainder and status flags. The result is ready W+2 cycles after start. One partial-remainder subtraction is performed per cycle on a (W+1)-bit adder-subtractor. Both unsigned and two's-complement signed division are supported, selected per operation.

## Interface
Parameters:
- W, 4, operand/result width in bits (W >= 2)

Ports:
- clk  input  1  system clock; all state changes on rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  request; sampled only in IDLE
- sgn  input  1  1 = signed two's-complement operands, 0 = unsigned; sampled with start
- dividend  input  W  numerator; sampled with start
- divisor  input  W  denominator; sampled with start
- busy  output  1  high whenever state != IDLE
- done  output  1  one-cycle pulse; result valid
- quotient  output  W  result quotient; held until next result
- remainder  output  W  result remainder; held until next result
- div0  output  1  divisor was zero; updated with result
- ovf  output  1  signed overflow (most-negative / -1); updated with result

## Operation
- FSM states: IDLE, CALC, FIX, DONE.
- IDLE:
  - start=1 and divisor!=0: latch |dividend| and |divisor|. Magnitudes are taken only when sgn=1; otherwise operands are latched raw. Also latch sgn, the dividend sign and the divisor sign. Clear the partial remainder R (W+1 bits). Set step counter = W-1 and go to CALC.
  - start=1 and divisor==0: go directly to DONE. Write quotient = all ones, remainder = dividend, div0 = 1, ovf = 0.
- CALC, one step per cycle:
  - Shift {R, Q} left by one, bringing in the dividend MSB.
  - Compute R - D on the (W+1)-bit adder-subtractor (se=1).
  - If the result is non-negative, R takes the result and the new quotient bit is 1. Otherwise R is restored and the quotient bit is 0.
  - After the step with counter 0, go to FIX.
- FIX:
  - If sgn and the operand signs differ, negate the quotient (two's complement).
  - If sgn and the dividend is negative, negate the remainder.
  - Register quotient, remainder, div0 = 0, and ovf = (sgn && dividend == most-negative && divisor == all ones). Go to DONE.
- DONE: done = 1 for this cycle only, then return to IDLE.
- Signed semantics: the quotient truncates toward zero; the remainder takes the dividend's sign.
- Overflow case (-2^(W-1) / -1): quotient = 2^(W-1) bit pattern, remainder = 0, ovf = 1. This case takes normal latency.
- start while busy is ignored; the operation in flight is unaffected.
- All arithmetic is modulo 2^W on the outputs. The internal remainder is W+1 bits, so that a borrow is visible as its MSB.

## Timing
- Reset values: state = IDLE, busy = 0, done = 0, quotient = 0, remainder = 0, div0 = 0, ovf = 0. Internal registers are cleared as well.
- Reset asserted mid-operation: at the next edge, return to IDLE with all outputs at reset values. No done pulse follows.
- Normal path: start is sampled at edge t. CALC steps occur at edges t+1..t+W, FIX at edge t+W+1. done is high in the cycle after edge t+W+1, and IDLE is re-entered at edge t+W+2.
- busy is high from the cycle after edge t through the done cycle.
- Divide-by-zero path: done is high in the cycle after edge t. busy is high for that single cycle.
- Back-to-back operation: a new start may be asserted in the first IDLE cycle after done.
- quotient, remainder, div0 and ovf change only at the FIX edge or the div0 edge. They are stable while done = 1 and afterwards.

## Structure
- Package seq_div_pkg holds:
  - the state enum (IDLE, CALC, FIX, DONE);
  - default W = 4;
  - the helper function for two's-complement negation.
- Sub-module addsub_n: a parameterized N-bit adder-subtractor with se input, B xor se, carry-in = se. It is instantiated with N = W+1 for the restoring step.
- Counter width: $clog2(W).

## Test plan
- Unsigned 13 / 3 (sgn=0, W=4) -> quotient 4'h4, remainder 4'h1, div0 = 0, ovf = 0; done exactly 6 cycles after the start edge.
- Signed -7 / 2 (4'h9 / 4'h2, sgn=1) -> quotient 4'hD (-3), remainder 4'hF (-1), ovf = 0.
- Signed -8 / -1 (4'h8 / 4'hF, sgn=1) -> quotient 4'h8, remainder 4'h0, ovf = 1, normal latency.
- 5 / 0 -> quotient 4'hF, remainder 4'h5, div0 = 1; done 1 cycle after start, busy high for that cycle only.
- Unsigned 7 / 9 -> quotient 0, remainder 7. A second start issued at cycle 2 is ignored, and the results are unchanged.
- Assert rst at cycle 3 of an operation -> next cycle all outputs 0, busy = 0, no done pulse. A following 15 / 4 -> quotient 3, remainder 3.

Source files
------------

// File: rtl/seq_div_pkg.sv
// rtl/seq_div_pkg.sv - shared types, default width and helpers for seq_div
package seq_div_pkg;

   // default operand/result width
   localparam int W_DEFAULT = 4;

   // controller states
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2,
      DONE = 2'd3
   } state_t;

   // two's-complement negation; callers cast the result down to their width
   function automatic logic [31:0] neg2c(input logic [31:0] v);
      return (~v) + 32'd1;
   endfunction

endpackage

// File: rtl/addsub_n.sv
// rtl/addsub_n.sv - N-bit adder-subtractor, s = a + (b ^ se) + se
module addsub_n #(
   parameter int N = 5
) (
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic         se,
   output logic [N-1:0] s
);

   // se=1 inverts b and injects the carry, giving a - b
   assign s = a + (b ^ {N{se}}) + {{(N-1){1'b0}}, se};

endmodule

// File: rtl/seq_div.sv
// rtl/seq_div.sv - sequential restoring divider, signed or unsigned per operation
module seq_div
   import seq_div_pkg::*;
#(
   parameter int W = W_DEFAULT
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic         sgn,
   input  logic [W-1:0] dividend,
   input  logic [W-1:0] divisor,
   output logic         busy,
   output logic         done,
   output logic [W-1:0] quotient,
   output logic [W-1:0] remainder,
   output logic         div0,
   output logic         ovf
);

   localparam int CW = $clog2(W);
   localparam logic [W-1:0] MOST_NEG = {1'b1, {(W-1){1'b0}}};

   state_t        state, state_nx;
   logic [CW-1:0] cnt;
   logic [W-1:0]  r;          // partial remainder between steps (always < d)
   logic [W-1:0]  q;          // dividend bits shift out as quotient bits shift in
   logic [W-1:0]  d;          // divisor magnitude
   logic          sgn_r;
   logic          dvd_neg;
   logic          dvs_neg;
   logic          ovf_r;

   logic [W:0]    r_sh;       // shifted partial remainder, one extra bit for the borrow
   logic [W:0]    diff;
   logic [W-1:0]  dvd_mag;
   logic [W-1:0]  dvs_mag;
   logic [W-1:0]  q_fix;
   logic [W-1:0]  r_fix;
   logic          dvs_zero;
   logic          ovf_det;

   assign r_sh = {r, q[W-1]};

   addsub_n #(.N(W+1)) u_addsub (
      .a  (r_sh),
      .b  ({1'b0, d}),
      .se (1'b1),
      .s  (diff)
   );

   assign dvs_zero = (divisor == '0);
   assign ovf_det  = sgn && (dividend == MOST_NEG) && (divisor == '1);
   assign dvd_mag  = (sgn && dividend[W-1]) ? W'(neg2c(32'(dividend))) : dividend;
   assign dvs_mag  = (sgn && divisor[W-1])  ? W'(neg2c(32'(divisor)))  : divisor;
   assign q_fix    = (sgn_r && (dvd_neg ^ dvs_neg)) ? W'(neg2c(32'(q))) : q;
   assign r_fix    = (sgn_r && dvd_neg) ? W'(neg2c(32'(r))) : r;

   // state register
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   // next-state logic
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (start) state_nx = dvs_zero ? DONE : CALC;
         CALC:    if (cnt == '0) state_nx = FIX;
         FIX:     state_nx = DONE;
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // status outputs decoded from state
   always_comb begin
      busy = (state != IDLE);
      done = (state == DONE);
   end

   // operand latch, restoring steps and result registers
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt       <= '0;
         r         <= '0;
         q         <= '0;
         d         <= '0;
         sgn_r     <= 1'b0;
         dvd_neg   <= 1'b0;
         dvs_neg   <= 1'b0;
         ovf_r     <= 1'b0;
         quotient  <= '0;
         remainder <= '0;
         div0      <= 1'b0;
         ovf       <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  if (dvs_zero) begin
                     quotient  <= '1;
                     remainder <= dividend;
                     div0      <= 1'b1;
                     ovf       <= 1'b0;
                  end else begin
                     q       <= dvd_mag;
                     d       <= dvs_mag;
                     r       <= '0;
                     sgn_r   <= sgn;
                     dvd_neg <= dividend[W-1];
                     dvs_neg <= divisor[W-1];
                     ovf_r   <= ovf_det;
                     cnt     <= CW'(W-1);
                  end
               end
            end
            CALC: begin
               // a clear borrow bit means the trial subtraction fits
               if (!diff[W]) begin
                  r <= diff[W-1:0];
                  q <= {q[W-2:0], 1'b1};
               end else begin
                  r <= r_sh[W-1:0];
                  q <= {q[W-2:0], 1'b0};
               end
               cnt <= cnt - 1'b1;
            end
            FIX: begin
               quotient  <= q_fix;
               remainder <= r_fix;
               div0      <= 1'b0;
               ovf       <= ovf_r;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_seq_div.sv
// tb/tb_seq_div.sv - directed self-checking bench for seq_div
module tb_seq_div;

   logic       clk;
   logic       rst;
   logic       start;
   logic       sgn;
   logic [3:0] dividend;
   logic [3:0] divisor;
   logic       busy;
   logic       done;
   logic [3:0] quotient;
   logic [3:0] remainder;
   logic       div0;
   logic       ovf;

   int n_tests;
   int n_fail;

   seq_div #(.W(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .sgn       (sgn),
      .dividend  (dividend),
      .divisor   (divisor),
      .busy      (busy),
      .done      (done),
      .quotient  (quotient),
      .remainder (remainder),
      .div0      (div0),
      .ovf       (ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // drive one start pulse; returns in the cycle after the start edge
   task automatic start_op(input logic s, input logic [3:0] a, input logic [3:0] b);
      sgn      = s;
      dividend = a;
      divisor  = b;
      start    = 1'b1;
      tick();
      start    = 1'b0;
   endtask

   // lat counts cycles since the start edge; cycle 1 is the one right after it
   task automatic wait_done(input int from, output int lat);
      lat = from;
      while (!done && lat < 40) begin
         tick();
         lat++;
      end
      if (!done) check("done_timeout", 32'(done), 32'd1);
   endtask

   task automatic check_result(input string tag, input logic [3:0] eq, input logic [3:0] er,
                               input logic ed0, input logic eov);
      check({tag, "_q"},    32'(quotient),  32'(eq));
      check({tag, "_r"},    32'(remainder), 32'(er));
      check({tag, "_div0"}, 32'(div0),      32'(ed0));
      check({tag, "_ovf"},  32'(ovf),       32'(eov));
   endtask

   initial begin
      int  lat;
      logic seen_done;
      n_tests  = 0;
      n_fail   = 0;
      rst      = 1'b1;
      start    = 1'b0;
      sgn      = 1'b0;
      dividend = '0;
      divisor  = '0;
      tick();
      tick();
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check_result("rst", 4'h0, 4'h0, 1'b0, 1'b0);
      rst = 1'b0;
      tick();

      // unsigned 13 / 3
      start_op(1'b0, 4'd13, 4'd3);
      check("u13_3_busy1", 32'(busy), 32'd1);
      check("u13_3_done1", 32'(done), 32'd0);
      wait_done(1, lat);
      check("u13_3_lat", 32'(lat), 32'd6);
      check_result("u13_3", 4'h4, 4'h1, 1'b0, 1'b0);
      tick();
      check("u13_3_pulse", 32'(done), 32'd0);
      check("u13_3_idle", 32'(busy), 32'd0);
      check("u13_3_hold_q", 32'(quotient), 32'h4);

      // signed -7 / 2, started in the first IDLE cycle after done
      start_op(1'b1, 4'h9, 4'h2);
      wait_done(1, lat);
      check("s_m7_2_lat", 32'(lat), 32'd6);
      check_result("s_m7_2", 4'hD, 4'hF, 1'b0, 1'b0);
      tick();

      // signed 7 / -2: divisor-only negative
      start_op(1'b1, 4'h7, 4'hE);
      wait_done(1, lat);
      check_result("s_7_m2", 4'hD, 4'h1, 1'b0, 1'b0);
      tick();

      // signed overflow -8 / -1
      start_op(1'b1, 4'h8, 4'hF);
      wait_done(1, lat);
      check("ovf_lat", 32'(lat), 32'd6);
      check_result("ovf", 4'h8, 4'h0, 1'b0, 1'b1);
      tick();

      // unsigned -8 bit pattern / 15 is an ordinary 8 / 15
      start_op(1'b0, 4'h8, 4'hF);
      wait_done(1, lat);
      check_result("u8_15", 4'h0, 4'h8, 1'b0, 1'b0);
      tick();

      // divide by zero
      start_op(1'b0, 4'd5, 4'd0);
      check("div0_busy1", 32'(busy), 32'd1);
      wait_done(1, lat);
      check("div0_lat", 32'(lat), 32'd1);
      check_result("div0", 4'hF, 4'h5, 1'b1, 1'b0);
      tick();
      check("div0_busy2", 32'(busy), 32'd0);
      check("div0_done2", 32'(done), 32'd0);

      // unsigned 15 / 1: full-width quotient
      start_op(1'b0, 4'hF, 4'h1);
      wait_done(1, lat);
      check_result("u15_1", 4'hF, 4'h0, 1'b0, 1'b0);
      tick();

      // unsigned 7 / 9 with a second start at cycle 2
      start_op(1'b0, 4'd7, 4'd9);
      sgn      = 1'b1;
      dividend = 4'h8;
      divisor  = 4'hF;
      start    = 1'b1;
      tick();
      start    = 1'b0;
      wait_done(2, lat);
      check("u7_9_lat", 32'(lat), 32'd6);
      check_result("u7_9", 4'h0, 4'h7, 1'b0, 1'b0);
      tick();
      check("u7_9_no_rerun", 32'(busy), 32'd0);

      // reset in cycle 3 of an operation
      start_op(1'b0, 4'd13, 4'd3);
      tick();
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("mid_rst_busy", 32'(busy), 32'd0);
      check("mid_rst_done", 32'(done), 32'd0);
      check_result("mid_rst", 4'h0, 4'h0, 1'b0, 1'b0);
      seen_done = 1'b0;
      for (int i = 0; i < 8; i++) begin
         seen_done = seen_done | done;
         tick();
      end
      check("mid_rst_no_done", 32'(seen_done), 32'd0);

      // operation after reset: 15 / 4
      start_op(1'b0, 4'd15, 4'd4);
      wait_done(1, lat);
      check("u15_4_lat", 32'(lat), 32'd6);
      check_result("u15_4", 4'h3, 4'h3, 1'b0, 1'b0);
      tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
